fifo_rd_packer: RTL and testbench

Read-side consumer for the small async FIFO, in the read clock domain. Pops DSIZE-bit entries from the FIFO read port and packs PACK consecutive entries into one wide word. Presents the word on a valid/ready output with a per-lane keep mask. Partial words are flushed on an explicit flush request or after an idle timeout, so trailing data never stalls in the packer.

---
 rtl/fifo_rd_packer_pkg.sv | 26 ++
 rtl/fifo_rd_packer_if.sv | 17 +
 rtl/fifo_word_outreg.sv | 37 +++
 rtl/fifo_rd_packer.sv | 96 +++++++++
 tb/tb_fifo_rd_packer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_packer_pkg.sv
// Shared constants and width helpers for the FIFO read-side packer.
package fifo_defs;

  localparam int DSIZE_DEF   = 8;
  localparam int PACK_DEF    = 4;
  localparam int TIMEOUT_DEF = 16;

  // One keep bit per lane, so the keep width equals the lane count.
  function automatic int keep_w(input int pack);
    return pack;
  endfunction

  // Lane counter must hold 0..PACK inclusive.
  function automatic int cnt_w(input int pack);
    return $clog2(pack + 1);
  endfunction

  // Idle counter holds 0..TIMEOUT; keep at least one bit when the timeout is disabled.
  function automatic int idle_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

  localparam int CNT_W_DEF  = cnt_w(PACK_DEF);
  localparam int IDLE_W_DEF = idle_w(TIMEOUT_DEF);

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Packed-word output bus of the read-side packer.
// Handshake: a word transfers on a rising edge where m_valid and m_ready are both
// high; while m_valid=1 and m_ready=0 the master holds m_data/m_keep/m_valid stable.
interface fifo_rd_packer_if
  import fifo_defs::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int PACK  = PACK_DEF
);
  logic [DSIZE*PACK-1:0] m_data;
  logic [PACK-1:0]       m_keep;
  logic                  m_valid;
  logic                  m_ready;

  modport master (output m_data, output m_keep, output m_valid, input m_ready);
  modport slave  (input m_data, input m_keep, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_word_outreg.sv
// Valid/ready holding register for packed output words.
module fifo_word_outreg
  import fifo_defs::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int PACK  = PACK_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DSIZE*PACK-1:0] data_i,
  input  logic [PACK-1:0]       keep_i,
  output logic                  slot_free_o,
  fifo_rd_packer_if.master      m_if
);

  // The slot can take a new word when empty or when the current one leaves this edge.
  always_comb begin
    slot_free_o = !m_if.m_valid || m_if.m_ready;
  end

  // Load a new word, or drop valid once the held word has been accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_if.m_data  <= '0;
      m_if.m_keep  <= '0;
      m_if.m_valid <= 1'b0;
    end else if (load_i) begin
      m_if.m_data  <= data_i;
      m_if.m_keep  <= keep_i;
      m_if.m_valid <= 1'b1;
    end else if (m_if.m_valid && m_if.m_ready) begin
      m_if.m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops FIFO entries and packs PACK of them into one wide word; partial words
// leave on a flush request or after TIMEOUT idle cycles.
module fifo_rd_packer
  import fifo_defs::*;
#(
  parameter int DSIZE   = DSIZE_DEF,
  parameter int PACK    = PACK_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int CNT_W  = cnt_w(PACK),
  localparam int IDLE_W = idle_w(TIMEOUT)
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  input  logic             flush,
  fifo_rd_packer_if.master m_if,
  output logic [CNT_W-1:0] dbg_cnt_o
);

  logic [PACK-1:0][DSIZE-1:0] acc_q;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDLE_W-1:0]          idle_q, idle_d;
  logic                       slot_free;
  logic                       timeout_hit;
  logic                       want_flush;
  logic                       load;
  logic [DSIZE*PACK-1:0]      word;
  logic [keep_w(PACK)-1:0]    keep;

  // Flush/pop decisions, the outgoing word image and counter next-state.
  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (idle_q == IDLE_W'(TIMEOUT));
    want_flush  = (cnt_q != '0) &&
                  ((cnt_q == CNT_W'(PACK)) || flush || timeout_hit);
    load        = want_flush && slot_free;
    // A full accumulator may still pop when its word leaves this same edge.
    rinc        = !rrst && !rempty && ((cnt_q < CNT_W'(PACK)) || load);

    word = '0;
    keep = '0;
    for (int i = 0; i < PACK; i++) begin
      if (CNT_W'(i) < cnt_q) begin
        word[i*DSIZE +: DSIZE] = acc_q[i];
        keep[i]                = 1'b1;
      end
    end

    cnt_d = cnt_q;
    if (load && rinc)  cnt_d = CNT_W'(1);
    else if (load)     cnt_d = '0;
    else if (rinc)     cnt_d = cnt_q + CNT_W'(1);

    idle_d = idle_q;
    if (rinc || load || (cnt_q == '0))
      idle_d = '0;
    else if ((cnt_q < CNT_W'(PACK)) && (idle_q != IDLE_W'(TIMEOUT)))
      idle_d = idle_q + IDLE_W'(1);
  end

  // Lane and idle counters.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt_q  <= '0;
      idle_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      idle_q <= idle_d;
    end
  end

  // Accumulator lanes; a pop during a load restarts packing at lane 0.
  always_ff @(posedge rclk) begin
    for (int i = 0; i < PACK; i++) begin
      if (rinc && ((load && i == 0) || (!load && CNT_W'(i) == cnt_q)))
        acc_q[i] <= rdata;
    end
  end

  assign dbg_cnt_o = cnt_q;

  fifo_word_outreg #(
    .DSIZE (DSIZE),
    .PACK  (PACK)
  ) u_outreg (
    .clk         (rclk),
    .rst         (rrst),
    .load_i      (load),
    .data_i      (word),
    .keep_i      (keep),
    .slot_free_o (slot_free),
    .m_if        (m_if)
  );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a queue model of the FIFO read port.
module tb_fifo_rd_packer;
  import fifo_defs::*;

  localparam int DSIZE   = 8;
  localparam int PACK    = 4;
  localparam int TIMEOUT = 16;
  localparam int W       = 36;

  logic             rclk = 1'b0;
  logic             rrst = 1'b1;
  logic [DSIZE-1:0] rdata = '0;
  logic             rempty = 1'b1;
  logic             rinc;
  logic             flush = 1'b0;
  logic [2:0]       dbg_cnt;

  fifo_rd_packer_if #(.DSIZE(DSIZE), .PACK(PACK)) m_if ();

  fifo_rd_packer #(
    .DSIZE   (DSIZE),
    .PACK    (PACK),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rdata     (rdata),
    .rempty    (rempty),
    .rinc      (rinc),
    .flush     (flush),
    .m_if      (m_if),
    .dbg_cnt_o (dbg_cnt)
  );

  // ---------------- clock ----------------
  always #5 rclk = ~rclk;

  // ---------------- counters / scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int run   = 0;
  int max_run = 0;
  int viol  = 0;
  int last_pop_edge = 0;
  bit pop_pend = 1'b0;
  logic [DSIZE-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void refresh();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? '0 : fifo_q[0];
  endfunction

  task automatic push(input logic [DSIZE-1:0] v);
    fifo_q.push_back(v);
    refresh();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge rclk);
      if (m_if.m_valid) seen = 1'b1;
    end
    if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic compare(input string tag);
    logic [W-1:0] g, e;
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check(tag, 64'(g), 64'(e));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- monitors / FIFO model ----------------
  always @(negedge rclk) begin
    pop_pend = (rinc === 1'b1);
    if (rinc && rempty) viol++;
    if (rinc) begin
      run++;
      if (run > max_run) max_run = run;
      last_pop_edge = cyc + 1;
    end else begin
      run = 0;
    end
    if (!rrst && m_if.m_valid && m_if.m_ready)
      got_q.push_back({m_if.m_keep, m_if.m_data});
  end

  always @(posedge rclk) begin
    logic [DSIZE-1:0] tmp;
    cyc++;
    if (pop_pend && fifo_q.size() > 0) tmp = fifo_q.pop_front();
    #1 refresh();
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    m_if.m_ready = 1'b1;
    tick(3);
    rrst = 1'b0;
    @(negedge rclk);
    check("rst_valid", 64'(m_if.m_valid), 64'd0);
    check("rst_data",  64'(m_if.m_data),  64'd0);
    check("rst_keep",  64'(m_if.m_keep),  64'd0);
    check("rst_cnt",   64'(dbg_cnt),      64'd0);
    check("rst_rinc",  64'(rinc),         64'd0);

    // Full words with free-flowing output.
    tick(1);
    max_run = 0;
    for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
    tick(14);
    check("t1_rinc_run", 64'(max_run), 64'd8);
    exp_q.push_back({4'hF, 32'h14131211});
    exp_q.push_back({4'hF, 32'h18171615});
    compare("t1_word");

    // Backpressure: output blocked for 20 cycles.
    m_if.m_ready = 1'b0;
    for (int i = 0; i < 12; i++) push(8'h21 + 8'(i));
    tick(10);
    @(negedge rclk);
    check("t2_data_mid", 64'(m_if.m_data), 64'h24232221);
    tick(10);
    @(negedge rclk);
    check("t2_cnt",   64'(dbg_cnt),       64'd4);
    check("t2_rinc",  64'(rinc),          64'd0);
    check("t2_valid", 64'(m_if.m_valid),  64'd1);
    check("t2_data",  64'(m_if.m_data),   64'h24232221);
    check("t2_keep",  64'(m_if.m_keep),   64'hF);
    check("t2_left",  64'(fifo_q.size()), 64'd4);
    tick(1);
    m_if.m_ready = 1'b1;
    tick(12);
    exp_q.push_back({4'hF, 32'h24232221});
    exp_q.push_back({4'hF, 32'h28272625});
    exp_q.push_back({4'hF, 32'h2C2B2A29});
    compare("t2_word");

    // Idle timeout on a two-entry partial word.
    push(8'hA1);
    push(8'hA2);
    wait_valid("t3", 40);
    check("t3_latency", 64'(cyc - last_pop_edge), 64'd17);
    tick(3);
    exp_q.push_back({4'h3, 32'h0000A2A1});
    compare("t3_word");

    // Explicit flush of three entries, then flush with nothing buffered.
    push(8'h31);
    push(8'h32);
    push(8'h33);
    tick(6);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    @(negedge rclk);
    check("t4_valid", 64'(m_if.m_valid), 64'd1);
    check("t4_keep",  64'(m_if.m_keep),  64'h7);
    check("t4_data",  64'(m_if.m_data),  64'h00333231);
    tick(3);
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      check("t4_empty_flush", 64'(m_if.m_valid), 64'd0);
    end
    tick(1);
    flush = 1'b0;
    tick(2);
    exp_q.push_back({4'h7, 32'h00333231});
    compare("t4_word");

    // Load and pop on the same edge.
    max_run = 0;
    for (int i = 0; i < 5; i++) push(8'h41 + 8'(i));
    wait_valid("t5", 20);
    check("t5_cnt", 64'(dbg_cnt), 64'd1);
    tick(25);
    check("t5_rinc_run", 64'(max_run), 64'd5);
    exp_q.push_back({4'hF, 32'h44434241});
    exp_q.push_back({4'h1, 32'h00000045});
    compare("t5_word");

    // Reset with a partial word buffered.
    push(8'h51);
    push(8'h52);
    tick(3);
    rrst = 1'b1;
    push(8'h53);
    @(negedge rclk);
    check("t6_rinc_rst", 64'(rinc), 64'd0);
    tick(1);
    rrst = 1'b0;
    @(negedge rclk);
    check("t6_valid", 64'(m_if.m_valid), 64'd0);
    check("t6_cnt",   64'(dbg_cnt),      64'd0);
    tick(1);
    push(8'h61);
    push(8'h62);
    push(8'h63);
    tick(10);
    exp_q.push_back({4'hF, 32'h63626153});
    compare("t6_word");

    check("rinc_when_empty", 64'(viol), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
